fb_draw_scheduler: RTL and testbench

- Owns the single framebuffer write port and the double-buffer swap.
- Runs N_REQ drawing requesters (background clear, platforms, doodle, HUD) one after another in fixed painter's order each frame. Only the granted requester's writes reach the framebuffer.
- Requests a buffer swap on the first frame tick after every requester has finished.
- Sits between the drawing sub-engines and framebuffer2. Drives its x/y/rgb_in/wr_en and buffer_using.

---
 rtl/fb_sched_pkg.sv | 30 +++
 rtl/fb_draw_scheduler_phase_watchdog.sv | 38 +++
 rtl/fb_draw_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_fb_draw_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared definitions for the framebuffer draw scheduler.
// Holds the FSM state enumeration, default geometry/timing constants and a
// small saturating-increment helper used by the dropped-frame counter.
package fb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        DRAW      = 2'd2,
        WAIT_SWAP = 2'd3
    } sched_state_t;

    localparam int FB_N_REQ   = 4;
    localparam int FB_DW      = 8;
    localparam int FB_CW      = 10;
    localparam int FB_TO_W    = 20;
    localparam int FB_TIMEOUT = 400000;

    // Increment an 8-bit counter, holding at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_draw_scheduler_phase_watchdog.sv
// Per-phase watchdog for the draw scheduler.
// Ports:
//   Clk, Reset_n : clock and asynchronous active-low reset
//   clear        : forces the counter back to zero (held while not drawing)
//   count        : advance the counter by one this cycle
//   expire       : high while the counter sits at TIMEOUT-1
// The counter stops at TIMEOUT-1, so it can never wrap.
module phase_watchdog
    import fb_sched_pkg::*;
#(
    parameter int TO_W    = FB_TO_W,
    parameter int TIMEOUT = FB_TIMEOUT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_r;

    // Cycle counter for the current phase, saturating at the limit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (count && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + TO_W'(1);
        end
    end

    assign expire = (cnt_r == LIMIT);

endmodule

// File: rtl/fb_draw_scheduler.sv
// Framebuffer draw scheduler.
// Owns the single framebuffer write port and the double-buffer swap. Each
// frame the requesters are run one at a time in painter's order (index 0
// first, N_REQ-1 last/on top); only the granted requester's writes reach the
// port. A swap is issued on the first frame_tick after the last pass ends.
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   frame_tick          : one-cycle pulse at the start of vblank
//   enable              : gates the start of new frames
//   req_x/req_y/req_color/req_we : packed per-requester write bus
//   req_done            : per-requester "pass finished" pulse
//   start               : one-hot pulse, first cycle of a requester's pass
//   grant               : one-hot level while a requester owns the port
//   fb_x/fb_y/fb_color/fb_we     : registered framebuffer write port
//   buffer_using        : back-buffer index, toggles with swap
//   swap                : one-cycle pulse when buffer_using toggles
//   busy                : high while a frame is being drawn
//   dropped_frames      : saturating count of ticks that found drawing unfinished
//   overrun             : sticky per-requester watchdog flags
module fb_draw_scheduler
    import fb_sched_pkg::*;
#(
    parameter int N_REQ   = FB_N_REQ,
    parameter int DW      = FB_DW,
    parameter int CW      = FB_CW,
    parameter int TO_W    = FB_TO_W,
    parameter int TIMEOUT = FB_TIMEOUT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_tick,
    input  logic                enable,
    input  logic [N_REQ*CW-1:0] req_x,
    input  logic [N_REQ*CW-1:0] req_y,
    input  logic [N_REQ*DW-1:0] req_color,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ-1:0]    req_done,
    output logic [N_REQ-1:0]    start,
    output logic [N_REQ-1:0]    grant,
    output logic [CW-1:0]       fb_x,
    output logic [CW-1:0]       fb_y,
    output logic [DW-1:0]       fb_color,
    output logic                fb_we,
    output logic                buffer_using,
    output logic                swap,
    output logic                busy,
    output logic [7:0]          dropped_frames,
    output logic [N_REQ-1:0]    overrun
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0]    LAST_PHASE = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_START     = 2'(START);
    localparam logic [1:0] ST_DRAW      = 2'(DRAW);
    localparam logic [1:0] ST_WAIT_SWAP = 2'(WAIT_SWAP);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [PW-1:0]    phase_r;
    logic [PW-1:0]    phase_nx_s;
    logic             is_draw_s;
    logic             done_hit_s;
    logic             expire_s;
    logic             phase_end_s;
    logic             swap_now_s;
    logic             drop_s;

    logic [N_REQ-1:0] start_r;
    logic [N_REQ-1:0] grant_r;
    logic [CW-1:0]    fb_x_r;
    logic [CW-1:0]    fb_y_r;
    logic [DW-1:0]    fb_color_r;
    logic             fb_we_r;
    logic             buffer_r;
    logic             swap_r;
    logic             busy_r;
    logic [7:0]       dropped_r;
    logic [N_REQ-1:0] overrun_r;

    assign is_draw_s   = (state_r == ST_DRAW);
    // Only the owner of the current phase can end it; stray done pulses are ignored.
    assign done_hit_s  = req_done[phase_r] & grant_r[phase_r];
    assign phase_end_s = is_draw_s & (done_hit_s | expire_s);

    phase_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (!is_draw_s),
        .count   (is_draw_s),
        .expire  (expire_s)
    );

    // Next-state logic: phase sequencing, swap decision and dropped-tick detection.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r;
        swap_now_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick && enable) begin
                    state_nx_s = ST_START;
                    phase_nx_s = {PW{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nx_s = ST_DRAW;
            end
            ST_DRAW: begin
                if (phase_end_s && (phase_r != LAST_PHASE)) begin
                    state_nx_s = ST_START;
                    phase_nx_s = phase_r + PW'(1);
                end else if (phase_end_s && frame_tick) begin
                    // Last pass finishing on a tick: that tick is the swap tick.
                    swap_now_s = 1'b1;
                    state_nx_s = enable ? ST_START : ST_IDLE;
                    phase_nx_s = {PW{1'b0}};
                end else if (phase_end_s) begin
                    state_nx_s = ST_WAIT_SWAP;
                end else begin
                    state_nx_s = ST_DRAW;
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_tick) begin
                    swap_now_s = 1'b1;
                    state_nx_s = enable ? ST_START : ST_IDLE;
                    phase_nx_s = {PW{1'b0}};
                end else begin
                    state_nx_s = ST_WAIT_SWAP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                phase_nx_s = {PW{1'b0}};
            end
        endcase
        drop_s = frame_tick & ((state_r == ST_START) | is_draw_s) & ~swap_now_s;
    end

    // State, control outputs, write-port pipeline and status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= {PW{1'b0}};
            start_r    <= {N_REQ{1'b0}};
            grant_r    <= {N_REQ{1'b0}};
            fb_x_r     <= {CW{1'b0}};
            fb_y_r     <= {CW{1'b0}};
            fb_color_r <= {DW{1'b0}};
            fb_we_r    <= 1'b0;
            buffer_r   <= 1'b0;
            swap_r     <= 1'b0;
            busy_r     <= 1'b0;
            dropped_r  <= 8'd0;
            overrun_r  <= {N_REQ{1'b0}};
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
            // START is a one-cycle gap with grant low; the pass's start pulse and
            // grant become visible together on the first DRAW cycle.
            start_r <= (state_r == ST_START) ? (ONE_HOT0 << phase_r) : {N_REQ{1'b0}};
            grant_r <= ((state_r == ST_START) || (is_draw_s && !phase_end_s))
                       ? (ONE_HOT0 << phase_r) : {N_REQ{1'b0}};
            fb_we_r    <= req_we[phase_r] & grant_r[phase_r];
            fb_x_r     <= req_x[phase_r*CW +: CW];
            fb_y_r     <= req_y[phase_r*CW +: CW];
            fb_color_r <= req_color[phase_r*DW +: DW];
            swap_r     <= swap_now_s;
            if (swap_now_s) begin
                buffer_r <= ~buffer_r;
            end
            busy_r <= (state_nx_s == ST_START) || (state_nx_s == ST_DRAW);
            if (drop_s) begin
                dropped_r <= sat_inc8(dropped_r);
            end
            if (is_draw_s && expire_s && !done_hit_s) begin
                overrun_r[phase_r] <= 1'b1;
            end
        end
    end

    assign start          = start_r;
    assign grant          = grant_r;
    assign fb_x           = fb_x_r;
    assign fb_y           = fb_y_r;
    assign fb_color       = fb_color_r;
    assign fb_we          = fb_we_r;
    assign buffer_using   = buffer_r;
    assign swap           = swap_r;
    assign busy           = busy_r;
    assign dropped_frames = dropped_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Self-checking bench for fb_draw_scheduler. The bench plays all requesters,
// keeps a frame-level model (which requester should own the port and for how
// many cycles, when a tick swaps or is dropped) and pushes expected writes and
// swaps into queues that a separate monitor drains.
module tb_fb_draw_scheduler;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int DW = 8;
    localparam int TO = 50;

    logic            Clk;
    logic            Reset_n;
    logic            frame_tick;
    logic            enable;
    logic [N*CW-1:0] req_x;
    logic [N*CW-1:0] req_y;
    logic [N*DW-1:0] req_color;
    logic [N-1:0]    req_we;
    logic [N-1:0]    req_done;
    logic [N-1:0]    start;
    logic [N-1:0]    grant;
    logic [CW-1:0]   fb_x;
    logic [CW-1:0]   fb_y;
    logic [DW-1:0]   fb_color;
    logic            fb_we;
    logic            buffer_using;
    logic            swap;
    logic            busy;
    logic [7:0]      dropped_frames;
    logic [N-1:0]    overrun;

    fb_draw_scheduler #(
        .N_REQ(N), .DW(DW), .CW(CW), .TO_W(20), .TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .enable(enable),
        .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_we(req_we),
        .req_done(req_done), .start(start), .grant(grant), .fb_x(fb_x),
        .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we),
        .buffer_using(buffer_using), .swap(swap), .busy(busy),
        .dropped_frames(dropped_frames), .overrun(overrun)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard queues.
    logic [2*CW+DW-1:0] wq[$];
    logic               sq[$];

    // Frame-level model. fstate: 0 idle, 1 drawing, 2 finished awaiting tick.
    int       fstate;
    int       act_k;          // requester currently owning the port, -1 none
    int       win_left;       // cycles left in its ownership window
    int       exp_phase;      // next requester to be started
    bit       start_pending;
    int       exp_start_cyc;
    logic     model_buf;
    int       exp_drop;
    logic [N-1:0] exp_ovr;
    int       dly[N];         // done delay after start, -1 = never (watchdog)
    bit       en_ctl;
    bit       force_wr;
    int       cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fstate = 0; act_k = -1; win_left = 0; exp_phase = 0; start_pending = 0;
        exp_start_cyc = 0; model_buf = 1'b0; exp_drop = 0; exp_ovr = '0;
    endtask

    task automatic new_frame();
        fstate = 1; exp_phase = 0; start_pending = 1; exp_start_cyc = cyc + 2;
    endtask

    task automatic do_swap();
        model_buf = ~model_buf;
        sq.push_back(model_buf);
        if (en_ctl) new_frame();
        else fstate = 0;
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, advance model.
    task automatic step(input bit tick);
        logic [N-1:0] exp_start;
        bit final_end;
        @(posedge Clk); #1;
        cyc++;
        exp_start = '0;
        if (start_pending && cyc == exp_start_cyc) begin
            exp_start = N'(1) << exp_phase;
            act_k = exp_phase;
            win_left = (dly[exp_phase] < 0) ? TO : dly[exp_phase] + 1;
            exp_phase++;
            start_pending = 0;
        end
        chk("start", 32'(start), 32'(exp_start));
        chk("grant", 32'(grant), (act_k >= 0) ? 32'(N'(1) << act_k) : 32'd0);
        chk("busy", 32'(busy), 32'(fstate == 1));
        chk("buffer", 32'(buffer_using), 32'(model_buf));

        for (int i = 0; i < N; i++) begin
            req_x[i*CW +: CW]     = CW'($urandom);
            req_y[i*CW +: CW]     = CW'($urandom);
            req_color[i*DW +: DW] = DW'($urandom);
        end
        req_we = N'($urandom);
        req_done = '0;
        for (int i = 0; i < N; i++)
            if (i != act_k && $urandom_range(0, 15) == 0) req_done[i] = 1'b1;
        if (force_wr && act_k == 1) begin
            req_x[CW +: CW] = 10'd140; req_y[CW +: CW] = 10'd200;
            req_color[DW +: DW] = 8'h1F; req_we[1] = 1'b1; req_we[2] = 1'b1;
        end

        final_end = 0;
        if (act_k >= 0) begin
            if (req_we[act_k])
                wq.push_back({req_x[act_k*CW +: CW], req_y[act_k*CW +: CW],
                              req_color[act_k*DW +: DW]});
            if (dly[act_k] >= 0 && win_left == 1) req_done[act_k] = 1'b1;
            win_left--;
            if (win_left == 0) begin
                if (dly[act_k] < 0) exp_ovr[act_k] = 1'b1;
                if (act_k == N - 1) final_end = 1;
                else begin start_pending = 1; exp_start_cyc = cyc + 2; end
                act_k = -1;
            end
        end

        frame_tick = tick;
        enable = en_ctl;
        if (tick && Reset_n) begin
            if (fstate == 0) begin
                if (en_ctl) new_frame();
            end else if (fstate == 1) begin
                if (final_end) do_swap();
                else if (exp_drop < 255) exp_drop++;
            end else begin
                do_swap();
            end
        end else if (final_end) begin
            fstate = 2;
        end
    endtask

    task automatic wait_fstate(input int want, input int budget);
        int n = 0;
        while (fstate != want && n < budget) begin step(1'b0); n++; end
        if (fstate != want) chk("wait_fstate_timeout", 32'(fstate), 32'(want));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        wq.delete(); sq.delete();
        model_reset();
        frame_tick = 1'b0; req_we = '0; req_done = '0;
        #1;
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_x", 32'(fb_x), 32'd0);
        chk("rst_fb_y", 32'(fb_y), 32'd0);
        chk("rst_fb_color", 32'(fb_color), 32'd0);
        chk("rst_swap", 32'(swap), 32'd0);
        chk("rst_dropped", 32'(dropped_frames), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) step(1'b0);
        Reset_n = 1'b1;
    endtask

    // Ends any frame in progress and leaves the scheduler idle.
    task automatic drain();
        int n = 0;
        en_ctl = 0;
        while (fstate != 0 && n < 1000) begin
            step(fstate == 2);
            n++;
        end
        if (fstate != 0) chk("drain_timeout", 32'(fstate), 32'd0);
    endtask

    // Monitor: every presented write or swap is matched against the scoreboard.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (fb_we) begin
                if (wq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_extra: got x=%0d y=%0d c=%0h expected no write",
                             fb_x, fb_y, fb_color);
                end else begin
                    chk("wr_data", 32'({fb_x, fb_y, fb_color}), 32'(wq.pop_front()));
                end
            end
            if (swap) begin
                if (sq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL swap_extra: got swap buf=%0d expected no swap", buffer_using);
                end else begin
                    chk("swap_buf", 32'(buffer_using), 32'(sq.pop_front()));
                end
            end
        end
    end

    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; enable = 1'b0;
        req_x = '0; req_y = '0; req_color = '0; req_we = '0; req_done = '0;
        en_ctl = 0; force_wr = 0;
        for (int i = 0; i < N; i++) dly[i] = 10;
        model_reset();
        do_reset();

        // Normal frame, then swap tick that also starts the next frame.
        en_ctl = 1;
        step(1'b1);
        wait_fstate(2, 400);
        step(1'b1);
        step(1'b0);
        chk("first_swap_buf", 32'(buffer_using), 32'd1);
        wait_fstate(2, 400);
        drain();

        // Write forwarding with requester 2 strobing alongside requester 1.
        force_wr = 1; en_ctl = 1;
        step(1'b1);
        wait_fstate(2, 400);
        force_wr = 0;
        drain();

        // Watchdog on the last requester.
        dly[3] = -1; en_ctl = 1;
        step(1'b1);
        wait_fstate(2, 800);
        step(1'b0);
        chk("overrun_last", 32'(overrun), 32'h8);
        drain();
        dly[3] = 10;

        // Randomized frames, ticks and pauses.
        for (int i = 0; i < 2500; i++) begin
            if (fstate != 1)
                for (int k = 0; k < N; k++) dly[k] = $urandom_range(0, 25);
            en_ctl = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 29) == 0);
        end
        drain();
        chk("rand_dropped", 32'(dropped_frames), 32'(exp_drop));
        chk("rand_overrun", 32'(overrun), 32'(exp_ovr));

        // Reset in the middle of requester 1's pass.
        for (int k = 0; k < N; k++) dly[k] = 10;
        en_ctl = 1;
        step(1'b1);
        begin
            int n = 0;
            while (act_k != 1 && n < 200) begin step(1'b0); n++; end
        end
        chk("pre_reset_grant", 32'(grant), 32'h2);
        do_reset();
        en_ctl = 0;
        for (int i = 0; i < 20; i++) step(i % 4 == 0);

        // Two ticks while drawing are dropped and do not swap.
        for (int k = 0; k < N; k++) dly[k] = 30;
        en_ctl = 1;
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        repeat (20) step(1'b0);
        step(1'b1);
        wait_fstate(2, 400);
        chk("two_dropped", 32'(dropped_frames), 32'd2);
        drain();

        // Ticks every third cycle through watchdog-limited frames saturate the count.
        for (int k = 0; k < N; k++) dly[k] = -1;
        en_ctl = 1;
        for (int i = 0; i < 1200; i++) step(i % 3 == 0);
        drain();
        chk("dropped_sat", 32'(dropped_frames), 32'd255);
        chk("sat_overrun", 32'(overrun), 32'hF);

        // Tick landing on the final done with enable low: swap, no drop, go idle.
        do_reset();
        for (int k = 0; k < N; k++) dly[k] = 10;
        en_ctl = 1;
        step(1'b1);
        begin
            int n = 0;
            while (!(act_k == N - 1 && win_left == 1) && n < 400) begin step(1'b0); n++; end
        end
        en_ctl = 0;
        step(1'b1);
        step(1'b0);
        chk("coinc_dropped", 32'(dropped_frames), 32'd0);
        chk("coinc_buf", 32'(buffer_using), 32'd1);
        for (int i = 0; i < 30; i++) step(i % 5 == 0);
        chk("coinc_idle", 32'(busy), 32'd0);

        repeat (3) step(1'b0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        chk("final_dropped", 32'(dropped_frames), 32'(exp_drop));
        chk("final_overrun", 32'(overrun), 32'(exp_ovr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
